// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a 2**AW-entry register file, with bounded locked bursts.
// Optional macro REGFILE_WRITE_ARBITER_ZERO_REG_EN hardwires register 0 (writes to it are accepted but suppressed).
module regfile_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   data,
  input  logic                 stall,
  output logic [NREQ-1:0]      gnt,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [(2**AW)-1:0]   wr_sel,
  output logic [DW-1:0]        wr_data,
  output logic                 busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW   = $clog2(MAX_BURST + 1);
  localparam int SELW = 2**AW;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [BW-1:0]   r_bcnt;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_cand;
  logic            w_found;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            w_lock;
  logic            w_last;
  logic            w_write_ok;
  logic [SELW-1:0] w_sel;

  // Grant selection: owner only while locked, otherwise first requester from r_ptr upward
  always_comb begin
    w_gnt   = {NREQ{1'b0}};
    w_idx   = {PW{1'b0}};
    w_cand  = {PW{1'b0}};
    w_found = 1'b0;
    if (rst || stall) begin
      w_found = 1'b0;
    end else if (r_state == ST_LOCKED) begin
      if (req[r_owner]) begin
        w_found = 1'b1;
        w_idx   = r_owner;
      end else begin
        w_found = 1'b0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        w_cand = PW'((int'(r_ptr) + i) % NREQ);
        if (!w_found && req[w_cand]) begin
          w_found = 1'b1;
          w_idx   = w_cand;
        end else begin
          w_found = w_found;
        end
      end
    end
    if (w_found) begin
      w_gnt[w_idx] = 1'b1;
    end else begin
      w_gnt = {NREQ{1'b0}};
    end
  end

  // Payload mux for the winning requester and write qualification
  always_comb begin
    w_addr = {AW{1'b0}};
    w_data = {DW{1'b0}};
    w_lock = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == PW'(i)) begin
        w_addr = addr[i*AW +: AW];
        w_data = data[i*DW +: DW];
        w_lock = lock[i];
      end else begin
        w_lock = w_lock;
      end
    end
    w_last = ((int'(r_bcnt) + 1) >= MAX_BURST);
`ifdef REGFILE_WRITE_ARBITER_ZERO_REG_EN
    w_write_ok = (w_addr != {AW{1'b0}});
`else
    w_write_ok = 1'b1;
`endif
    if (w_write_ok) begin
      w_sel = {{(SELW-1){1'b0}}, 1'b1} << w_addr;
    end else begin
      w_sel = {SELW{1'b0}};
    end
  end

  // Arbitration FSM and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {PW{1'b0}};
      r_owner <= {PW{1'b0}};
      r_bcnt  <= {BW{1'b0}};
      wr_en   <= 1'b0;
      wr_addr <= {AW{1'b0}};
      wr_sel  <= {SELW{1'b0}};
      wr_data <= {DW{1'b0}};
    end else if (w_found) begin
      wr_en  <= w_write_ok;
      wr_sel <= w_sel;
      if (w_write_ok) begin
        wr_addr <= w_addr;
        wr_data <= w_data;
      end else begin
        wr_addr <= wr_addr;
        wr_data <= wr_data;
      end
      case (r_state)
        ST_IDLE: begin
          r_ptr <= (w_idx == PW'(NREQ - 1)) ? {PW{1'b0}} : (w_idx + {{(PW-1){1'b0}}, 1'b1});
          if (w_lock) begin
            r_state <= ST_LOCKED;
            r_owner <= w_idx;
            r_bcnt  <= {{(BW-1){1'b0}}, 1'b1};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // Release on an unlocked write or when the burst budget is used up
          if (!w_lock || w_last) begin
            r_state <= ST_IDLE;
            r_bcnt  <= {BW{1'b0}};
          end else begin
            r_bcnt  <= r_bcnt + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_bcnt  <= {BW{1'b0}};
        end
      endcase
    end else begin
      wr_en  <= 1'b0;
      wr_sel <= {SELW{1'b0}};
      // Owner dropped its request at an unstalled edge: abandon the lock
      if (!stall && (r_state == ST_LOCKED)) begin
        r_state <= ST_IDLE;
        r_bcnt  <= {BW{1'b0}};
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign gnt  = w_gnt;
  assign busy = (r_state == ST_LOCKED);

endmodule
